// File: rtl/sigmoid_pe_pkg.sv
// Shared types and constants for the sigmoid neuron processing element.
//   pe_state_t  : control FSM states
//   act_mode_t  : activation select (sigmoid LUT / clamped ReLU)
//   sig_thresh  : ascending pre-activation thresholds of the sigmoid staircase;
//                 sigmoid output = number of thresholds <= pre
package sigmoid_pe_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACCUM    = 3'd1,
        DRAIN    = 3'd2,
        ACTIVATE = 3'd3,
        DONE     = 3'd4
    } pe_state_t;

    typedef enum logic {
        ACT_SIGMOID = 1'b0,
        ACT_RELU    = 1'b1
    } act_mode_t;

    localparam int SIG_NUM_T = 8;

    // Output steps up by one each time pre reaches one of these values:
    // <-5:0, -5..-3:1, -2:2, -1:3, 0:4, 1:5, 2:6, 3..5:7, >5:8
    function automatic int sig_thresh(input int idx);
        case (idx)
            0:       return -5;
            1:       return -2;
            2:       return -1;
            3:       return 0;
            4:       return 1;
            5:       return 2;
            6:       return 3;
            default: return 6;
        endcase
    endfunction

endpackage

// File: rtl/sigmoid_pe_activation.sv
// Combinational activation stage.
//   pre      : signed pre-activation value
//   act_mode : ACT_SIGMOID -> 0..8 staircase, ACT_RELU -> clamp(pre, 0, 2^OUT_W-1)
//   out_data : activation result (registered by the parent)
module sigmoid_pe_activation
    import sigmoid_pe_pkg::*;
#(
    parameter int PRE_W = 16,
    parameter int OUT_W = 4
) (
    input  logic signed [PRE_W-1:0] pre,
    input  act_mode_t               act_mode,
    output logic        [OUT_W-1:0] out_data
);

    localparam int RELU_MAX = (1 << OUT_W) - 1;

    logic [3:0]       sig_cnt;
    logic [OUT_W-1:0] relu_val;

    always_comb begin
        sig_cnt = '0;
        for (int i = 0; i < SIG_NUM_T; i++) begin
            if (int'(pre) >= sig_thresh(i)) sig_cnt = sig_cnt + 4'd1;
        end
    end

    always_comb begin
        if (int'(pre) <= 0)             relu_val = '0;
        else if (int'(pre) > RELU_MAX)  relu_val = OUT_W'(RELU_MAX);
        else                            relu_val = pre[OUT_W-1:0];
    end

    assign out_data = (act_mode == ACT_RELU) ? relu_val : OUT_W'(sig_cnt);

endmodule

// File: rtl/sigmoid_neuron_pe.sv
// Neuron PE: LANES signed-weight x unsigned-input products per beat, summed and
// accumulated (saturating) over num_beats beats, then sigmoid or ReLU.
//   clk/n_rst            : clock, async active-low reset
//   start, num_beats,
//   act_mode, bias       : neuron setup, sampled in IDLE only
//   in_valid/in_ready    : beat handshake, weights/inputs packed lane 0 in LSBs
//   out_valid/out_ready  : result handshake, out_data/overflow held in DONE
//   busy, accum_out      : status / debug
module sigmoid_neuron_pe
    import sigmoid_pe_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int WEIGHT_W = 4,
    parameter int INPUT_W  = 4,
    parameter int ACC_W    = 16,
    parameter int BIAS_W   = 4,
    parameter int OUT_W    = 4,
    parameter int BEAT_W   = 8
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        start,
    input  logic [BEAT_W-1:0]           num_beats,
    input  logic                        act_mode,
    input  logic [BIAS_W-1:0]           bias,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*WEIGHT_W-1:0]   weights,
    input  logic [LANES*INPUT_W-1:0]    inputs,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_W-1:0]            out_data,
    output logic                        overflow,
    output logic                        busy,
    output logic [ACC_W-1:0]            accum_out
);

    localparam int PROD_W = WEIGHT_W + INPUT_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam int STAGES = 3;  // product, lane sum, accumulate

    pe_state_t state_q, state_d;

    logic                     accept;
    logic [STAGES-1:0]        vld_q;
    logic [LANES-1:0][PROD_W-1:0] lane_p, prod_q;
    logic [SUM_W-1:0]         sum_d, sum_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [ACC_W:0]           acc_wide;
    logic signed [ACC_W-1:0]  acc_sat;
    logic                     sat;
    logic [BEAT_W-1:0]        nb_q, beat_cnt_q;
    act_mode_t                mode_q;
    logic [BIAS_W-1:0]        bias_q;
    logic                     ovf_q;
    logic [OUT_W-1:0]         out_data_q, act_out;
    logic signed [ACC_W-1:0]  bias_ext, pre;
    logic                     last_beat;

    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt_q == nb_q - BEAT_W'(1));

    // Per-lane product; operands widened to PROD_W so the truncated product is exact.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [PROD_W-1:0] w_ext, x_ext;
        assign w_ext = {{INPUT_W{weights[g*WEIGHT_W+WEIGHT_W-1]}}, weights[g*WEIGHT_W +: WEIGHT_W]};
        assign x_ext = {{WEIGHT_W{1'b0}}, inputs[g*INPUT_W +: INPUT_W]};
        assign lane_p[g] = w_ext * x_ext;
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++)
            sum_d = sum_d + {{(SUM_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
    end

    // One extra bit of headroom: differing top two bits mean the add left the ACC_W range.
    always_comb begin
        acc_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-SUM_W){sum_q[SUM_W-1]}}, sum_q};
        sat      = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
        if (!sat)                acc_sat = acc_wide[ACC_W-1:0];
        else if (acc_wide[ACC_W]) acc_sat = {1'b1, {(ACC_W-1){1'b0}}};
        else                     acc_sat = {1'b0, {(ACC_W-1){1'b1}}};
    end

    assign bias_ext = {{(ACC_W-BIAS_W){bias_q[BIAS_W-1]}}, bias_q};
    assign pre      = (bias_ext <<< 1) + (acc_q >>> 2);

    sigmoid_pe_activation #(.PRE_W(ACC_W), .OUT_W(OUT_W)) u_act (
        .pre      (pre),
        .act_mode (mode_q),
        .out_data (act_out)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = (num_beats == '0) ? DRAIN : ACCUM;
            ACCUM:    if (accept && last_beat) state_d = DRAIN;
            DRAIN:    if (vld_q == '0) state_d = ACTIVATE;
            ACTIVATE: state_d = DONE;
            DONE:     if (out_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE:    busy      = 1'b0;
            ACCUM:   in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath. vld_q[2] marks the cycle after the accumulator update so DRAIN
    // also waits for the final add to land before ACTIVATE reads acc_q.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_q      <= '0;
            prod_q     <= '0;
            sum_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            nb_q       <= '0;
            beat_cnt_q <= '0;
            mode_q     <= ACT_SIGMOID;
            bias_q     <= '0;
            out_data_q <= '0;
        end else begin
            vld_q  <= {vld_q[STAGES-2:0], accept};
            prod_q <= lane_p;
            sum_q  <= sum_d;
            if (state_q == IDLE && start) begin
                nb_q       <= num_beats;
                mode_q     <= act_mode_t'(act_mode);
                bias_q     <= bias;
                acc_q      <= '0;
                ovf_q      <= 1'b0;
                beat_cnt_q <= '0;
            end else begin
                if (accept) beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                if (vld_q[1]) begin
                    acc_q <= acc_sat;
                    if (sat) ovf_q <= 1'b1;
                end
            end
            if (state_q == ACTIVATE) out_data_q <= act_out;
        end
    end

    assign out_data  = out_data_q;
    assign overflow  = ovf_q;
    assign accum_out = acc_q;

endmodule

// File: tb/tb_sigmoid_neuron_pe.sv
// Scoreboard bench for sigmoid_neuron_pe: the driver computes each neuron's
// expected result from plain integer arithmetic and queues it; a negedge
// monitor compares whenever the PE presents a result.
module tb_sigmoid_neuron_pe;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [7:0]  num_beats;
    logic        act_mode;
    logic [3:0]  bias;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] weights;
    logic [15:0] inputs;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        overflow;
    logic        busy;
    logic [15:0] accum_out;

    sigmoid_neuron_pe dut (
        .clk(clk), .n_rst(n_rst), .start(start), .num_beats(num_beats),
        .act_mode(act_mode), .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
        .weights(weights), .inputs(inputs), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .overflow(overflow), .busy(busy), .accum_out(accum_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int ovf;
        int out;
        int nb;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int floor_div4(input int a);
        if (a >= 0) return a / 4;
        return -((-a + 3) / 4);
    endfunction

    function automatic int ref_sigmoid(input int p);
        if (p < -5)  return 0;
        if (p <= -3) return 1;
        if (p == -2) return 2;
        if (p == -1) return 3;
        if (p == 0)  return 4;
        if (p == 1)  return 5;
        if (p == 2)  return 6;
        if (p <= 5)  return 7;
        return 8;
    endfunction

    function automatic int ref_relu(input int p);
        if (p <= 0)  return 0;
        if (p > 15)  return 15;
        return p;
    endfunction

    // ---------------- monitor ----------------
    bit   prev_ov = 0;
    bit   prev_hs = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (!n_rst) begin
            prev_ov = 0;
            prev_hs = 0;
        end else begin
            if (in_valid && in_ready) last_acc = cyc + 1;
            if (prev_hs) chk("valid_drop", int'(out_valid), 0);
            prev_hs = 0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("spurious_out_valid");
                end else begin
                    cur = exp_q[0];
                    if (!prev_ov && cur.nb > 0) chk("latency", cyc - last_acc, 5);
                    chk("out_data", int'(out_data), cur.out);
                    chk("overflow", int'(overflow), cur.ovf);
                    if (out_ready) begin
                        chk("accum_out", int'($signed(accum_out)), cur.acc);
                        void'(exp_q.pop_front());
                        prev_hs = 1;
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- driver ----------------
    task automatic run_neuron(input int nb, input bit mode, input logic [3:0] b,
                              input bit fixed, input logic [3:0] wf, input logic [3:0] xf,
                              input bit gaps, input int hold, input bit poke);
        logic [15:0] wv [128];
        logic [15:0] xv [128];
        exp_t e;
        int   acc, bs, n, pre;
        acc   = 0;
        e.ovf = 0;
        for (int k = 0; k < nb; k++) begin
            if (fixed) begin
                wv[k] = {4{wf}};
                xv[k] = {4{xf}};
            end else begin
                wv[k] = 16'($urandom);
                xv[k] = 16'($urandom);
            end
            bs = 0;
            for (int l = 0; l < 4; l++)
                bs += int'($signed(wv[k][l*4 +: 4])) * int'(xv[k][l*4 +: 4]);
            acc += bs;
            if (acc > 32767)       begin acc = 32767;  e.ovf = 1; end
            else if (acc < -32768) begin acc = -32768; e.ovf = 1; end
        end
        pre   = 2 * int'($signed(b)) + floor_div4(acc);
        e.acc = acc;
        e.nb  = nb;
        e.out = mode ? ref_relu(pre) : ref_sigmoid(pre);

        n = 0;
        while (busy && n < 300) begin step(); n++; end
        if (busy) begin fail_now("idle_timeout"); return; end

        // a stray beat offered while idle must not be consumed
        if (gaps) begin
            in_valid = 1'b1; weights = 16'($urandom); inputs = 16'($urandom);
            step();
        end
        exp_q.push_back(e);
        num_beats = 8'(nb); act_mode = mode; bias = b; start = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b0;

        for (int k = 0; k < nb; k++) begin
            if (gaps) begin
                n = $urandom_range(0, 2);
                in_valid = 1'b0;
                repeat (n) step();
            end
            in_valid = 1'b1; weights = wv[k]; inputs = xv[k];
            n = 0;
            while (!in_ready && n < 20) begin step(); n++; end
            if (!in_ready) begin in_valid = 1'b0; fail_now("in_ready_timeout"); return; end
            step();
        end
        // keep offering junk during drain in gap mode; it must be ignored
        in_valid = gaps; weights = 16'($urandom); inputs = 16'($urandom);

        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        in_valid = 1'b0;
        if (!out_valid) begin fail_now("out_valid_timeout"); return; end
        for (int h = 0; h < hold; h++) begin
            if (poke && h == hold / 2) begin start = 1'b1; num_beats = 8'd3; end
            step();
            start = 1'b0;
            chk("hold_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; num_beats = '0; act_mode = 1'b0; bias = '0;
        in_valid = 1'b0; weights = '0; inputs = '0; out_ready = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data",  int'(out_data), 0);
        chk("rst_overflow",  int'(overflow), 0);
        chk("rst_in_ready",  int'(in_ready), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_accum",     int'(accum_out), 0);
        n_rst = 1'b1;
        step();

        // directed: acc 840 -> 8; -4 -> 3; bias -2 -> 1; saturation -> 0
        run_neuron(2,   0, 4'h0, 1, 4'h7, 4'hF, 0, 0, 0);
        run_neuron(1,   0, 4'h0, 1, 4'hF, 4'h1, 0, 0, 0);
        run_neuron(1,   0, 4'hE, 1, 4'hF, 4'h1, 0, 0, 0);
        run_neuron(100, 0, 4'h0, 1, 4'h8, 4'hF, 0, 0, 0);
        // ReLU clamp and zero-beat neuron
        run_neuron(2,   1, 4'h0, 1, 4'h7, 4'hF, 0, 0, 0);
        run_neuron(0,   1, 4'hF, 1, 4'h0, 4'h0, 0, 0, 0);
        // input gaps, then a long output stall with ignored start pulses
        run_neuron(2,   0, 4'h0, 1, 4'h7, 4'hF, 1, 0, 0);
        run_neuron(3,   1, 4'h3, 1, 4'h1, 4'h2, 0, 10, 1);

        // reset in the middle of accumulation
        num_beats = 8'd4; act_mode = 1'b0; bias = 4'h0; start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1; weights = 16'h7777; inputs = 16'hFFFF;
        repeat (3) step();
        in_valid = 1'b0;
        step(); step();
        chk("pre_rst_busy",  int'(busy), 1);
        chk("pre_rst_accum", int'(accum_out), 1260);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out_data",  int'(out_data), 0);
        chk("mid_rst_overflow",  int'(overflow), 0);
        chk("mid_rst_in_ready",  int'(in_ready), 0);
        chk("mid_rst_busy",      int'(busy), 0);
        chk("mid_rst_accum",     int'(accum_out), 0);
        step();
        n_rst = 1'b1;
        step();
        run_neuron(2, 0, 4'h0, 1, 4'h7, 4'hF, 0, 0, 0);

        // randomized neurons
        for (int t = 0; t < 30; t++)
            run_neuron($urandom_range(0, 6), 1'($urandom), 4'($urandom), 0, 4'h0, 4'h0,
                       1'($urandom), $urandom_range(0, 3), 1'($urandom));

        repeat (3) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sigmoid_neuron_pe.md
Name: sigmoid_neuron_pe

Overview:
- Parametrised neuron processing element: LANES signed-weight × unsigned-input products per beat, accumulated over a run-time number of beats, then passed through a selectable activation (sigmoid LUT or clamped ReLU).
- Adds what the fixed 4-lane ALU lacks: ready/valid handshakes, an internal beat counter and FSM, saturating accumulation with a sticky overflow flag, a mode select, and output backpressure.
- Sits between the weight/input buffers and the hidden/output-layer result registers.

Parameters:
LANES, 4, products summed per beat
WEIGHT_W, 4, signed weight width (s3.0)
INPUT_W, 4, unsigned input width (1.3)
ACC_W, 16, signed accumulator width
BIAS_W, 4, signed bias width
OUT_W, 4, activation output width
BEAT_W, 8, width of beat count

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  begin new neuron; sampled only in IDLE
num_beats  in  BEAT_W  beats in this neuron; latched on start
act_mode  in  1  0 = sigmoid, 1 = ReLU; latched on start
bias  in  BIAS_W  signed bias; latched on start
in_valid  in  1  beat valid
in_ready  out  1  PE accepts a beat
weights  in  LANES*WEIGHT_W  packed, lane 0 in LSBs
inputs  in  LANES*INPUT_W  packed, lane 0 in LSBs
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  OUT_W  activation result
overflow  out  1  accumulator saturated during this neuron (sticky)
busy  out  1  state != IDLE
accum_out  out  ACC_W  accumulator value, debug

Behaviour:
- Reset (n_rst=0, asynchronous): state IDLE; accumulator, beat counter and pipeline valids 0; out_valid=0; out_data=0; overflow=0; in_ready=0; busy=0.
- FSM states: IDLE, ACCUM, DRAIN, ACTIVATE, DONE.
- IDLE, start=1: latch num_beats, act_mode and bias; clear accumulator and overflow.
  - Next state ACCUM, or DRAIN if num_beats==0 (result uses acc=0).
- ACCUM: in_ready=1. A beat is accepted when in_valid && in_ready. Beat counter increments per accepted beat. Accepting beat num_beats-1 → DRAIN, with in_ready=0 from the following cycle.
- Pipeline, for a beat accepted at cycle t:
  - t+1: LANES products registered; width WEIGHT_W+INPUT_W, input zero-extended.
  - t+2: signed lane sum registered; width WEIGHT_W+INPUT_W+clog2(LANES).
  - t+3: accumulator updated.
- DRAIN: wait until all pipeline valid bits are 0, then → ACTIVATE.
- ACTIVATE (1 cycle): compute pre = (bias sign-extended, <<1) + (acc >>> 2). Register out_data. → DONE.
- Latency: out_valid rises 5 cycles after the last beat is accepted.
- DONE: out_valid=1. out_data and overflow are held stable until out_ready=1. On the handshake → IDLE and out_valid drops next cycle. start is ignored outside IDLE.
- Saturation: the accumulator add is evaluated at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets overflow, which stays set until the next start.
- Sigmoid map (pre → out): < -5 → 0; -5..-3 → 1; -2 → 2; -1 → 3; 0 → 4; 1 → 5; 2 → 6; 3..5 → 7; > 5 → 8.
- ReLU map: pre ≤ 0 → 0; otherwise min(pre, 2^OUT_W-1).
- in_valid while not in ACCUM: ignored; no beat is consumed.

Decomposition:
- Package sigmoid_pe_pkg holds:
  - pe_state_t enum (IDLE, ACCUM, DRAIN, ACTIVATE, DONE)
  - act_mode_t enum (ACT_SIGMOID=0, ACT_RELU=1)
  - sigmoid threshold constants
- Sub-module sigmoid_pe_activation: combinational; inputs pre and act_mode, output out_data. The top level registers its output.

Test Plan:
1. Weights all 4'h7, inputs all 4'hF, bias 0, sigmoid, num_beats=2 → acc=840, pre=210, out_data=8 exactly 5 cycles after the second beat; overflow=0.
2. Weights all 4'hF (-1), inputs all 1, num_beats=1: bias 0 → acc=-4, out_data=3. Repeat with bias 4'hE → pre=-5, out_data=1.
3. Weights 4'h8 (-8), inputs 4'hF, num_beats=100 → acc=-32768, overflow=1, out_data=0.
4. Scenario 1 with act_mode=1 → out_data=15. num_beats=0 with bias 4'hF → pre=-2, out_data=0.
5. Backpressure and stalls:
   - Drop in_valid between beats: no extra beats counted, result unchanged.
   - Hold out_ready=0 for 10 cycles: out_valid and out_data stay stable; start pulses during this time are ignored.
6. Deassert n_rst mid-ACCUM → all outputs return to their reset values immediately. A following start with scenario 1 stimulus reproduces out_data=8.
